gpio_axil_arbiter: RTL and testbench

// - Shares one AXI4-Lite GPIO slave (DATA reg 0x0, DIR reg 0x4) between NUM_REQ on-chip requesters.
// - Round-robin arbiter plus AXI4-Lite master FSM: one outstanding transaction, fully serialised.
// - Sits between CPU/DMA/test-controller request ports and the GPIO slave's S_AXI port.

---
 rtl/gpio_axil_pkg.sv | 30 +++
 rtl/rr_arbiter.sv | 35 +++
 rtl/gpio_axil_arbiter.sv | 221 ++++++++++++++++++++++
 tb/tb_gpio_axil_arbiter.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gpio_axil_pkg.sv
// Shared types and constants for the GPIO AXI4-Lite request arbiter.
// Holds the master FSM state encoding, the GPIO register map and the AXI response codes.
// Also carries the round-robin pointer advance helper used by the top level.
package gpio_axil_pkg;

  // Master FSM states; one AXI4-Lite transaction in flight at a time.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_ADDR = 3'd1,
    WR_RESP = 3'd2,
    RD_ADDR = 3'd3,
    RD_DATA = 3'd4
  } state_e;

  // GPIO slave register map (byte addresses).
  localparam logic [3:0] GPIO_DATA_ADDR = 4'h0;
  localparam logic [3:0] GPIO_DIR_ADDR  = 4'h4;

  // AXI BRESP/RRESP encodings.
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Round-robin successor of a granted index: (idx + 1) modulo n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner selection: first set request at or after ptr, wrapping modulo N.
// Purely combinational, zero latency; the pointer register lives in the parent.
// No backpressure of its own; the parent decides when a grant is taken.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  // Scan N positions starting at ptr; the first requester found wins.
  always_comb begin
    int pos;
    pos   = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      pos = int'(ptr) + k;
      if (pos >= N) begin
        pos = pos - N;
      end
      if (!any && req[pos]) begin
        any        = 1'b1;
        grant[pos] = 1'b1;
        idx        = IW'(pos);
      end
    end
  end

endmodule

// File: rtl/gpio_axil_arbiter.sv
// Shares one AXI4-Lite GPIO slave between NUM_REQ requesters via round-robin arbitration.
// Best case: request sampled c0, AW/W valid c1, B handshake c2, rsp_valid pulse c3.
// Requests wait while a transaction is in flight; AXI valids hold until their own ready.
module gpio_axil_arbiter
  import gpio_axil_pkg::*;
#(
  parameter int NUM_REQ            = 4,
  parameter int C_M_AXI_DATA_WIDTH = 32,
  parameter int C_M_AXI_ADDR_WIDTH = 4
) (
  input  logic                                  S_AXI_ACLK,
  input  logic                                  S_AXI_ARESETN,
  // requester side
  input  logic [NUM_REQ-1:0]                    req_valid,
  input  logic [NUM_REQ-1:0]                    req_write,
  input  logic [NUM_REQ*C_M_AXI_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*C_M_AXI_DATA_WIDTH-1:0] req_wdata,
  input  logic [NUM_REQ*C_M_AXI_DATA_WIDTH/8-1:0] req_wstrb,
  output logic [NUM_REQ-1:0]                    req_ready,
  output logic [NUM_REQ-1:0]                    rsp_valid,
  output logic [C_M_AXI_DATA_WIDTH-1:0]         rsp_rdata,
  output logic [1:0]                            rsp_resp,
  output logic                                  busy,
  // AXI4-Lite master
  output logic [C_M_AXI_ADDR_WIDTH-1:0]         M_AXI_AWADDR,
  output logic                                  M_AXI_AWVALID,
  input  logic                                  M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]         M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0]       M_AXI_WSTRB,
  output logic                                  M_AXI_WVALID,
  input  logic                                  M_AXI_WREADY,
  input  logic [1:0]                            M_AXI_BRESP,
  input  logic                                  M_AXI_BVALID,
  output logic                                  M_AXI_BREADY,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]         M_AXI_ARADDR,
  output logic                                  M_AXI_ARVALID,
  input  logic                                  M_AXI_ARREADY,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]         M_AXI_RDATA,
  input  logic [1:0]                            M_AXI_RRESP,
  input  logic                                  M_AXI_RVALID,
  output logic                                  M_AXI_RREADY
);

  localparam int DW = C_M_AXI_DATA_WIDTH;
  localparam int AW = C_M_AXI_ADDR_WIDTH;
  localparam int SW = C_M_AXI_DATA_WIDTH / 8;
  localparam int IW = $clog2(NUM_REQ);

  // FSM and arbitration state
  state_e              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       gnt_q, gnt_d;

  // captured request fields, driven straight onto the AXI channels
  logic [AW-1:0]       addr_q, addr_d;
  logic [DW-1:0]       wdata_q, wdata_d;
  logic [SW-1:0]       wstrb_q, wstrb_d;

  // AXI valid flags
  logic                awvalid_q, awvalid_d;
  logic                wvalid_q, wvalid_d;
  logic                arvalid_q, arvalid_d;

  // requester-facing registered outputs
  logic [NUM_REQ-1:0]  req_ready_q, req_ready_d;
  logic [NUM_REQ-1:0]  rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]       rsp_rdata_q, rsp_rdata_d;
  logic [1:0]          rsp_resp_q, rsp_resp_d;

  // arbiter results
  logic [NUM_REQ-1:0]  arb_grant;
  logic [IW-1:0]       arb_idx;
  logic                arb_any;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr_arbiter (
    .req   (req_valid),
    .ptr   (ptr_q),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  // Next-state and datapath: arbitrate in IDLE, then walk one AXI transaction to completion.
  always_comb begin
    int sel;
    sel         = int'(arb_idx);
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    wstrb_d     = wstrb_q;
    awvalid_d   = awvalid_q;
    wvalid_d    = wvalid_q;
    arvalid_d   = arvalid_q;
    req_ready_d = '0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_resp_d  = rsp_resp_q;

    case (state_q)
      IDLE: begin
        if (arb_any) begin
          // Accept pulse and AXI valids land on the same edge as the capture.
          req_ready_d = arb_grant;
          gnt_d       = arb_idx;
          ptr_d       = IW'(rr_next(sel, NUM_REQ));
          addr_d      = req_addr[sel*AW +: AW];
          wdata_d     = req_wdata[sel*DW +: DW];
          wstrb_d     = req_wstrb[sel*SW +: SW];
          if (req_write[sel]) begin
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            state_d   = WR_ADDR;
          end else begin
            arvalid_d = 1'b1;
            state_d   = RD_ADDR;
          end
        end
      end

      WR_ADDR: begin
        // AW and W complete independently; leave only once both have handshaken.
        if (awvalid_q && M_AXI_AWREADY) begin
          awvalid_d = 1'b0;
        end
        if (wvalid_q && M_AXI_WREADY) begin
          wvalid_d = 1'b0;
        end
        if (!awvalid_d && !wvalid_d) begin
          state_d = WR_RESP;
        end
      end

      WR_RESP: begin
        if (M_AXI_BVALID) begin
          rsp_resp_d           = M_AXI_BRESP;
          rsp_rdata_d          = '0;
          rsp_valid_d[gnt_q]   = 1'b1;
          state_d              = IDLE;
        end
      end

      RD_ADDR: begin
        if (M_AXI_ARREADY) begin
          arvalid_d = 1'b0;
          state_d   = RD_DATA;
        end
      end

      RD_DATA: begin
        if (M_AXI_RVALID) begin
          rsp_resp_d           = M_AXI_RRESP;
          rsp_rdata_d          = M_AXI_RDATA;
          rsp_valid_d[gnt_q]   = 1'b1;
          state_d              = IDLE;
        end
      end

      default: begin
        state_d   = IDLE;
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        arvalid_d = 1'b0;
      end
    endcase
  end

  // State registers; reset mid-transaction abandons it without a response.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      gnt_q       <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      wstrb_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      arvalid_q   <= 1'b0;
      req_ready_q <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      wstrb_q     <= wstrb_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      arvalid_q   <= arvalid_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_resp_q  <= rsp_resp_d;
    end
  end

  // Output mapping; response-channel readies follow the state so they are 0 in reset.
  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_resp      = rsp_resp_q;
  assign busy          = (state_q != IDLE);
  assign M_AXI_AWADDR  = addr_q;
  assign M_AXI_AWVALID = awvalid_q;
  assign M_AXI_WDATA   = wdata_q;
  assign M_AXI_WSTRB   = wstrb_q;
  assign M_AXI_WVALID  = wvalid_q;
  assign M_AXI_BREADY  = (state_q == WR_RESP);
  assign M_AXI_ARADDR  = addr_q;
  assign M_AXI_ARVALID = arvalid_q;
  assign M_AXI_RREADY  = (state_q == RD_DATA);

endmodule

// File: tb/tb_gpio_axil_arbiter.sv
// Bench for gpio_axil_arbiter: directed scenarios plus randomized request rounds.
// A negedge-driven GPIO slave model answers the AXI side with configurable delays.
// Expected grants/responses come from a round-robin model over the pending set.
module tb_gpio_axil_arbiter;
  import gpio_axil_pkg::*;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 4;
  localparam int SW = 4;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]    req_valid, req_write, req_ready, rsp_valid;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*SW-1:0] req_wstrb;
  logic [DW-1:0]   rsp_rdata;
  logic [1:0]      rsp_resp;
  logic            busy;
  logic [AW-1:0]   m_awaddr, m_araddr;
  logic [DW-1:0]   m_wdata, s_rdata;
  logic [SW-1:0]   m_wstrb;
  logic            m_awvalid, m_wvalid, m_bready, m_arvalid, m_rready;
  logic            s_awready, s_wready, s_bvalid, s_arready, s_rvalid;
  logic [1:0]      s_bresp, s_rresp;

  gpio_axil_arbiter #(.NUM_REQ(N), .C_M_AXI_DATA_WIDTH(DW), .C_M_AXI_ADDR_WIDTH(AW)) dut (
    .S_AXI_ACLK(clk), .S_AXI_ARESETN(arst_n),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp), .busy(busy),
    .M_AXI_AWADDR(m_awaddr), .M_AXI_AWVALID(m_awvalid), .M_AXI_AWREADY(s_awready),
    .M_AXI_WDATA(m_wdata), .M_AXI_WSTRB(m_wstrb), .M_AXI_WVALID(m_wvalid), .M_AXI_WREADY(s_wready),
    .M_AXI_BRESP(s_bresp), .M_AXI_BVALID(s_bvalid), .M_AXI_BREADY(m_bready),
    .M_AXI_ARADDR(m_araddr), .M_AXI_ARVALID(m_arvalid), .M_AXI_ARREADY(s_arready),
    .M_AXI_RDATA(s_rdata), .M_AXI_RRESP(s_rresp), .M_AXI_RVALID(s_rvalid), .M_AXI_RREADY(m_rready)
  );

  // ---------------- slave model configuration and registers ----------------
  int          cfg_aw_dly = 0, cfg_w_dly = 0, cfg_r_dly = 0;
  logic [1:0]  cfg_resp = 2'b00;
  logic [31:0] gpio_in = 32'h0;
  logic [31:0] s_data = 32'h0, s_dir = 32'h0;
  int          b_count = 0;

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                        input logic [3:0] strb);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Slave: decides ready/valid at negedge, so handshakes complete at the following posedge.
  bit aw_got, w_got, ar_got, aw_fire, w_fire, ar_fire, b_fire, r_fire;
  int aw_cnt, w_cnt, r_cnt;
  logic [3:0]  l_awaddr, l_araddr;
  logic [31:0] l_wdata;
  logic [3:0]  l_wstrb;
  initial begin
    s_awready = 0; s_wready = 0; s_arready = 0; s_bvalid = 0; s_rvalid = 0;
    s_bresp = 0; s_rresp = 0; s_rdata = 0;
  end
  always @(negedge clk) begin
    if (!arst_n) begin
      s_awready = 0; s_wready = 0; s_arready = 0; s_bvalid = 0; s_rvalid = 0;
      aw_got = 0; w_got = 0; ar_got = 0; aw_fire = 0; w_fire = 0; ar_fire = 0;
      b_fire = 0; r_fire = 0; aw_cnt = 0; w_cnt = 0; r_cnt = 0;
    end else begin
      if (b_fire) begin s_bvalid = 0; b_fire = 0; end
      if (r_fire) begin s_rvalid = 0; r_fire = 0; end
      if (aw_fire) begin aw_got = 1; aw_fire = 0; end
      if (w_fire) begin w_got = 1; w_fire = 0; end
      if (ar_fire) begin ar_got = 1; ar_fire = 0; end
      s_awready = 0; s_wready = 0; s_arready = 0;
      if (m_awvalid && !aw_got) begin
        if (aw_cnt >= cfg_aw_dly) begin
          s_awready = 1; aw_fire = 1; l_awaddr = m_awaddr; aw_cnt = 0;
        end else aw_cnt++;
      end
      if (m_wvalid && !w_got) begin
        if (w_cnt >= cfg_w_dly) begin
          s_wready = 1; w_fire = 1; l_wdata = m_wdata; l_wstrb = m_wstrb; w_cnt = 0;
        end else w_cnt++;
      end
      if (m_arvalid && !ar_got) begin
        s_arready = 1; ar_fire = 1; l_araddr = m_araddr;
      end
      if (aw_got && w_got && !s_bvalid) begin
        if (l_awaddr == GPIO_DIR_ADDR) s_dir = merge(s_dir, l_wdata, l_wstrb);
        else if (l_awaddr == GPIO_DATA_ADDR) s_data = merge(s_data, l_wdata, l_wstrb);
        s_bvalid = 1; s_bresp = cfg_resp; aw_got = 0; w_got = 0; b_count++;
      end
      if (ar_got && !s_rvalid) begin
        if (r_cnt >= cfg_r_dly) begin
          s_rvalid = 1; s_rresp = cfg_resp; ar_got = 0; r_cnt = 0;
          s_rdata = (l_araddr == GPIO_DATA_ADDR) ? gpio_in :
                    (l_araddr == GPIO_DIR_ADDR) ? s_dir : 32'h0;
        end else r_cnt++;
      end
      if (s_bvalid && m_bready) b_fire = 1;
      if (s_rvalid && m_rready) r_fire = 1;
    end
  end

  // ---------------- checking ----------------
  int checks = 0, errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit outs_zero();
    return ({req_ready, rsp_valid, rsp_rdata, rsp_resp, busy, m_awaddr, m_awvalid, m_wdata,
             m_wstrb, m_wvalid, m_bready, m_araddr, m_arvalid, m_rready} == '0);
  endfunction

  // ---------------- reference model ----------------
  logic [N-1:0] pend_mask = '0;
  logic         pend_write [N];
  logic [3:0]   pend_addr  [N];
  logic [31:0]  pend_wdata [N];
  logic [3:0]   pend_wstrb [N];
  int           mptr = 0;
  logic [31:0]  m_dir = 32'h0, m_data = 32'h0;
  int           grant_cnt [N];

  task automatic drive_req();
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = pend_mask[i];
      req_write[i]           = pend_write[i];
      req_addr[i*AW +: AW]   = pend_addr[i];
      req_wdata[i*DW +: DW]  = pend_wdata[i];
      req_wstrb[i*SW +: SW]  = pend_wstrb[i];
    end
  endtask

  task automatic set_req(input int i, input logic wr, input logic [3:0] a,
                         input logic [31:0] d, input logic [3:0] s);
    pend_mask[i] = 1'b1; pend_write[i] = wr; pend_addr[i] = a;
    pend_wdata[i] = d; pend_wstrb[i] = s;
  endtask

  // Winner: first pending requester at or after the model pointer, modulo N.
  function automatic int model_winner();
    for (int k = 0; k < N; k++) if (pend_mask[(mptr + k) % N]) return (mptr + k) % N;
    return 0;
  endfunction

  // Apply a grant of requester w to the model; returns the response data it should see.
  task automatic model_apply(input int w, output logic [31:0] exp_rd);
    mptr = (w + 1) % N;
    grant_cnt[w]++;
    if (pend_write[w]) begin
      if (pend_addr[w] == GPIO_DIR_ADDR) m_dir = merge(m_dir, pend_wdata[w], pend_wstrb[w]);
      else if (pend_addr[w] == GPIO_DATA_ADDR) m_data = merge(m_data, pend_wdata[w], pend_wstrb[w]);
      exp_rd = 32'h0;
    end else begin
      exp_rd = (pend_addr[w] == GPIO_DATA_ADDR) ? gpio_in :
               (pend_addr[w] == GPIO_DIR_ADDR) ? m_dir : 32'h0;
    end
  endtask

  // Serve pending requests; keep=1 holds every requester valid (re-requesting).
  task automatic serve(input int max_grants, input bit keep, input bit chk_lat);
    int served, t, w;
    logic [31:0] exp_rd;
    served = 0;
    drive_req();
    while (pend_mask != 0 && served < max_grants) begin
      @(negedge clk); t = 1;
      while (req_ready == 0 && t < 40) begin @(negedge clk); t++; end
      check("grant_seen", req_ready != 0, 1);
      if (req_ready == 0) return;
      w = model_winner();
      check("grant_onehot", req_ready, 64'(1) << w);
      if (chk_lat && served == 0) check("grant_latency", t, 1);
      if (pend_write[w]) begin
        check("awvalid", m_awvalid, 1); check("wvalid", m_wvalid, 1);
        check("awaddr", m_awaddr, pend_addr[w]); check("wdata", m_wdata, pend_wdata[w]);
        check("wstrb", m_wstrb, pend_wstrb[w]);
      end else begin
        check("arvalid", m_arvalid, 1); check("araddr", m_araddr, pend_addr[w]);
      end
      model_apply(w, exp_rd);
      if (!keep) pend_mask[w] = 1'b0;
      else if (served + 1 == max_grants) pend_mask = '0;
      drive_req();
      @(negedge clk); t = 1;
      while (rsp_valid == 0 && t < 60) begin @(negedge clk); t++; end
      check("rsp_seen", rsp_valid != 0, 1);
      if (rsp_valid == 0) return;
      check("rsp_onehot", rsp_valid, 64'(1) << w);
      check("rsp_rdata", rsp_rdata, exp_rd);
      check("rsp_resp", rsp_resp, cfg_resp);
      check("busy_at_rsp", busy, 0);
      if (chk_lat) check("rsp_latency", t, 2);
      served++;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish (observed timeout, required finish)");
    $fatal(1);
  end

  initial begin
    int t, bc;
    logic [31:0] exp_rd;
    for (int i = 0; i < N; i++) begin
      pend_write[i] = 0; pend_addr[i] = 0; pend_wdata[i] = 0; pend_wstrb[i] = 0; grant_cnt[i] = 0;
    end
    drive_req();

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs_zero", outs_zero(), 1);
    arst_n = 1'b1;
    @(negedge clk);
    check("idle_not_busy", busy, 0);

    // req0 writes DIR=0xFF with best-case latency
    set_req(0, 1'b1, GPIO_DIR_ADDR, 32'hFF, 4'h1);
    serve(1, 0, 1);
    check("slave_dir", s_dir, 32'hFF);

    // req1 reads DATA with gpio_in=0xA5
    gpio_in = 32'hA5;
    set_req(1, 1'b0, GPIO_DATA_ADDR, 32'h0, 4'h0);
    serve(1, 0, 1);

    // all four held continuously: two full rounds, each requester twice
    for (int i = 0; i < N; i++) begin
      grant_cnt[i] = 0;
      set_req(i, 1'b0, GPIO_DIR_ADDR, 32'h0, 4'h0);
    end
    serve(8, 1, 1);
    for (int i = 0; i < N; i++) check("rr_fairness", grant_cnt[i], 2);

    // AWREADY after 1 cycle, WREADY after 3 cycles
    cfg_aw_dly = 1; cfg_w_dly = 3; bc = b_count;
    set_req(3, 1'b1, GPIO_DATA_ADDR, 32'h1234_5678, 4'hF);
    drive_req();
    @(negedge clk);
    check("split_grant", req_ready, 64'(1) << model_winner());
    model_apply(3, exp_rd);
    pend_mask = '0; drive_req();
    repeat (2) @(negedge clk);
    check("split_aw_dropped", m_awvalid, 0);
    check("split_w_held", m_wvalid, 1);
    repeat (2) @(negedge clk);
    check("split_w_dropped", m_wvalid, 0);
    t = 0;
    while (rsp_valid == 0 && t < 20) begin @(negedge clk); t++; end
    check("split_rsp", rsp_valid, 4'b1000);
    check("split_rdata", rsp_rdata, 0);
    @(negedge clk);
    check("split_single_pulse", rsp_valid, 0);
    check("split_single_b", b_count - bc, 1);
    cfg_aw_dly = 0; cfg_w_dly = 0;

    // error response then normal service
    cfg_resp = RESP_SLVERR;
    set_req(2, 1'b1, GPIO_DATA_ADDR, 32'h5A, 4'hF);
    serve(1, 0, 1);
    cfg_resp = RESP_OKAY;
    gpio_in = 32'h3C;
    set_req(0, 1'b0, GPIO_DATA_ADDR, 32'h0, 4'h0);
    serve(1, 0, 1);

    // reset while waiting in RD_DATA
    cfg_r_dly = 20;
    set_req(1, 1'b0, GPIO_DIR_ADDR, 32'h0, 4'h0);
    drive_req();
    t = 0;
    while (req_ready == 0 && t < 20) begin @(negedge clk); t++; end
    check("rst_grant", req_ready, 4'b0010);
    pend_mask = '0; drive_req();
    t = 0;
    while (m_rready == 0 && t < 20) begin @(negedge clk); t++; end
    check("rst_in_rd_data", m_rready, 1);
    arst_n = 1'b0;
    #1;
    check("rst_async_outputs_zero", outs_zero(), 1);
    mptr = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("rst_no_rsp", rsp_valid, 0);
    end
    arst_n = 1'b1;
    cfg_r_dly = 0;
    @(negedge clk);
    // req1 and req3 pending: a cleared pointer picks req1 first
    gpio_in = 32'hC0DE;
    set_req(3, 1'b0, GPIO_DATA_ADDR, 32'h0, 4'h0);
    set_req(1, 1'b0, GPIO_DIR_ADDR, 32'h0, 4'h0);
    serve(2, 0, 1);

    // randomized rounds
    for (int r = 0; r < 12; r++) begin
      cfg_aw_dly = $urandom_range(0, 3);
      cfg_w_dly  = $urandom_range(0, 3);
      cfg_r_dly  = $urandom_range(0, 3);
      cfg_resp   = 2'($urandom_range(0, 3));
      gpio_in    = $urandom;
      for (int i = 0; i < N; i++) begin
        pend_write[i] = 1'($urandom_range(0, 1));
        pend_addr[i]  = ($urandom_range(0, 1) == 1) ? GPIO_DIR_ADDR : GPIO_DATA_ADDR;
        pend_wdata[i] = $urandom;
        pend_wstrb[i] = 4'($urandom_range(0, 15));
      end
      pend_mask = 4'($urandom_range(1, 15));
      serve(N, 0, 0);
      repeat (2) @(negedge clk);
    end
    check("final_dir_reg", s_dir, m_dir);
    check("final_data_reg", s_data, m_data);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
